// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed 7-segment display driver. DIGITS hex digits share one
// segment bus; a free-running prescaler sets the slot length and the PWM phase,
// and one anode is enabled per slot. Display content comes from shadow
// registers captured on 'load', so the upstream datapath may change its
// outputs freely between loads.
//
// Ports
//   clk        : system clock, rising edge
//   clr        : asynchronous active-low reset; darkens the display at once
//   load       : capture digits_in / dp_in / blank_in / lz_en into shadow
//   digits_in  : 4*DIGITS hex nibbles, digit k = [4k+3:4k], digit 0 rightmost
//   dp_in      : per-digit decimal point request
//   blank_in   : per-digit force-dark (segments and decimal point)
//   lz_en      : leading-zero suppression enable
//   brightness : PWM level, 0 = dimmest lit, all-ones = always on
//   seg        : {a,b,c,d,e,f,g}, polarity per SEG_ACT_LO
//   dp         : decimal point, polarity per SEG_ACT_LO
//   anode_sig  : one-hot digit enable, polarity per AN_ACT_LO
//   scan_idx   : index of the digit currently driven
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned PWM_BITS   = 3,
    parameter bit          SEG_ACT_LO = 1'b1,
    parameter bit          AN_ACT_LO  = 1'b1
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        load,
    input  logic [4*DIGITS-1:0]         digits_in,
    input  logic [DIGITS-1:0]           dp_in,
    input  logic [DIGITS-1:0]           blank_in,
    input  logic                        lz_en,
    input  logic [PWM_BITS-1:0]         brightness,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [DIGITS-1:0]           anode_sig,
    output logic [$clog2(DIGITS)-1:0]   scan_idx
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    // Inactive levels of the pins, used on reset and when a digit is dark.
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACT_LO}};
    localparam logic              DP_OFF  = SEG_ACT_LO;
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACT_LO}};

    // Active-high segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h7B;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;
            4'hD: pat = 7'h3D;
            4'hE: pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

    // Shadow copy of the display content.
    logic [4*DIGITS-1:0] sh_digits;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic                sh_lz;

    // Scan state. cur_idx is the live slot; scan_idx is its registered echo
    // so that it lines up with seg/dp/anode_sig.
    logic [DIV_WIDTH-1:0] prescaler;
    logic [IDX_W-1:0]     cur_idx;

    // Next values of the output registers.
    logic [6:0]        seg_next;
    logic              dp_next;
    logic [DIGITS-1:0] an_next;

    always_comb begin
        logic [DIGITS-1:0] suppress;
        logic              higher_clear;
        logic [3:0]        nib;
        logic [3:0]        cur_nib;
        logic              cur_dp;
        logic              cur_blank;
        logic              cur_dark;
        logic              pwm_on;
        logic [6:0]        pattern;
        logic [DIGITS-1:0] onehot;

        // NOTE: every variable assigned in this block gets a default first so
        // no path leaves it holding a previous value, which would infer a latch.
        suppress     = '0;
        higher_clear = 1'b1;
        nib          = '0;
        cur_nib      = '0;
        cur_dp       = 1'b0;
        cur_blank    = 1'b0;
        cur_dark     = 1'b0;
        onehot       = '0;

        // Leading-zero walk from the most significant digit downwards: a zero
        // digit is suppressed only while everything above it is zero or
        // blanked. Digit 0 is left out so a value of zero still shows "0".
        for (int k = DIGITS - 1; k >= 1; k--) begin
            nib         = sh_digits[4*k +: 4];
            suppress[k] = sh_lz && higher_clear && (nib == 4'h0);
            higher_clear = higher_clear && ((nib == 4'h0) || sh_blank[k]);
        end

        for (int k = 0; k < DIGITS; k++) begin
            if (cur_idx == IDX_W'(k)) begin
                cur_nib   = sh_digits[4*k +: 4];
                cur_dp    = sh_dp[k];
                cur_blank = sh_blank[k];
                cur_dark  = sh_blank[k] | suppress[k];
            end
        end

        // The top PWM_BITS of the prescaler form a sawtooth within the slot;
        // the anode is enabled for the low part of it.
        pwm_on = (prescaler[DIV_WIDTH-1 -: PWM_BITS] <= brightness);

        for (int k = 0; k < DIGITS; k++) begin
            onehot[k] = pwm_on && (cur_idx == IDX_W'(k));
        end

        // A suppressed digit keeps its decimal point; a blanked one does not.
        pattern  = cur_dark ? 7'h00 : hex_to_seg(cur_nib);
        seg_next = pattern ^ SEG_OFF;
        dp_next  = (cur_dp & ~cur_blank) ^ DP_OFF;
        an_next  = onehot ^ AN_OFF;
    end

    // Segments, anodes and scan_idx are all registered from the same
    // snapshot of state, so an anode can never pair with stale segments.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_lz     <= 1'b0;
            prescaler <= '0;
            cur_idx   <= '0;
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
            anode_sig <= AN_OFF;
            scan_idx  <= '0;
        end else begin
            if (load) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
                sh_lz     <= lz_en;
            end

            prescaler <= prescaler + 1'b1;
            if (prescaler == '1) begin
                cur_idx <= (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
            end

            seg       <= seg_next;
            dp        <= dp_next;
            anode_sig <= an_next;
            scan_idx  <= cur_idx;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed bench for seg_scan_driver with DIGITS=4, DIV_WIDTH=4, PWM_BITS=2.
// One instance uses active-low pins, a second shares its inputs and uses
// active-high pins. The bench counts clock edges since reset release; after
// edge n the outputs show slot ((n-1)/16)%4 at prescaler phase (n-1)%16.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        clr;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic [1:0]  brightness;

    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  anode_sig;
    logic [1:0]  scan_idx;

    logic [6:0]  seg_h;
    logic        dp_h;
    logic [3:0]  anode_h;
    logic [1:0]  scan_idx_h;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGITS(4), .DIV_WIDTH(4), .PWM_BITS(2), .SEG_ACT_LO(1'b1), .AN_ACT_LO(1'b1)
    ) dut (
        .clk(clk), .clr(clr), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_en(lz_en), .brightness(brightness),
        .seg(seg), .dp(dp), .anode_sig(anode_sig), .scan_idx(scan_idx)
    );

    seg_scan_driver #(
        .DIGITS(4), .DIV_WIDTH(4), .PWM_BITS(2), .SEG_ACT_LO(1'b0), .AN_ACT_LO(1'b0)
    ) dut_h (
        .clk(clk), .clr(clr), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_en(lz_en), .brightness(brightness),
        .seg(seg_h), .dp(dp_h), .anode_sig(anode_h), .scan_idx(scan_idx_h)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dpv;
        logic [3:0]  blank;
        logic        lz;
        logic [1:0]  bright;
        int          idx;
        int          pre;
        bit          seg_chk;
        logic [6:0]  seg;
        logic        dp;
        logic [3:0]  an;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit at_state(input int idx, input int pre);
        return (((cyc - 1) % 16) == pre) && ((((cyc - 1) / 16) % 4) == idx);
    endfunction

    // Always advances at least one edge, then stops when the sampled outputs
    // belong to slot idx at prescaler phase pre.
    task automatic advance_to(input int idx, input int pre);
        int n;
        n = 0;
        step();
        while (!at_state(idx, pre) && n < 80) begin
            step();
            n++;
        end
        if (!at_state(idx, pre)) begin
            checks++;
            failures++;
            $display("FAIL advance_to: slot %0d phase %0d not reached", idx, pre);
        end
    endtask

    task automatic load_vals(input logic [15:0] d, input logic [3:0] p,
                             input logic [3:0] b, input logic z);
        digits_in = d;
        dp_in     = p;
        blank_in  = b;
        lz_en     = z;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic add(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                       input logic z, input logic [1:0] br, input int idx, input int pre,
                       input bit sc, input logic [6:0] s, input logic dpe, input logic [3:0] an);
        vec_t v;
        v.digits = d; v.dpv = p; v.blank = b; v.lz = z; v.bright = br;
        v.idx = idx; v.pre = pre; v.seg_chk = sc; v.seg = s; v.dp = dpe; v.an = an;
        vecs.push_back(v);
    endtask

    initial begin
        int lit;

        // Expected values are active-low: seg = ~pattern, anode 0 = on.
        // Plain scan of 1A3F (digit0=F, 1=3, 2=A, 3=1), full brightness.
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd3, 0, 5,  1, 7'h38, 1'b1, 4'b1110);
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd3, 1, 0,  1, 7'h06, 1'b1, 4'b1101);
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd3, 2, 15, 1, 7'h08, 1'b1, 4'b1011);
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd3, 3, 8,  1, 7'h4F, 1'b1, 4'b0111);
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd3, 0, 2,  1, 7'h38, 1'b1, 4'b1110);
        // PWM edges: brightness 0 lit for phases 0-3, brightness 2 for 0-11.
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd0, 1, 3,  1, 7'h06, 1'b1, 4'b1101);
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd0, 1, 4,  0, 7'h00, 1'b1, 4'b1111);
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd2, 2, 11, 1, 7'h08, 1'b1, 4'b1011);
        add(16'h1A3F, 4'h0, 4'h0, 1'b0, 2'd2, 2, 12, 0, 7'h00, 1'b1, 4'b1111);
        // Leading-zero suppression of 0050 with dp on digit 3.
        add(16'h0050, 4'h8, 4'h0, 1'b1, 2'd3, 3, 0,  1, 7'h7F, 1'b0, 4'b0111);
        add(16'h0050, 4'h8, 4'h0, 1'b1, 2'd3, 2, 6,  1, 7'h7F, 1'b1, 4'b1011);
        add(16'h0050, 4'h8, 4'h0, 1'b1, 2'd3, 1, 6,  1, 7'h24, 1'b1, 4'b1101);
        add(16'h0050, 4'h8, 4'h0, 1'b1, 2'd3, 0, 6,  1, 7'h01, 1'b1, 4'b1110);
        // All-zero value: only digit 0 shows.
        add(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 3, 1,  1, 7'h7F, 1'b1, 4'b0111);
        add(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 2, 1,  1, 7'h7F, 1'b1, 4'b1011);
        add(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 1, 1,  1, 7'h7F, 1'b1, 4'b1101);
        add(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, 0, 1,  1, 7'h01, 1'b1, 4'b1110);
        // Blanked top digit counts as clear for suppression; blank kills dp.
        add(16'h7005, 4'h9, 4'h8, 1'b1, 2'd3, 3, 3,  1, 7'h7F, 1'b1, 4'b0111);
        add(16'h7005, 4'h9, 4'h8, 1'b1, 2'd3, 2, 3,  1, 7'h7F, 1'b1, 4'b1011);
        add(16'h7005, 4'h9, 4'h8, 1'b1, 2'd3, 1, 3,  1, 7'h7F, 1'b1, 4'b1101);
        add(16'h7005, 4'h9, 4'h8, 1'b1, 2'd3, 0, 3,  1, 7'h24, 1'b0, 4'b1110);
        add(16'h7005, 4'h9, 4'h8, 1'b0, 2'd3, 2, 9,  1, 7'h01, 1'b1, 4'b1011);
        // More decode values: DB62.
        add(16'hDB62, 4'h0, 4'h0, 1'b0, 2'd3, 0, 7,  1, 7'h12, 1'b1, 4'b1110);
        add(16'hDB62, 4'h0, 4'h0, 1'b0, 2'd3, 1, 7,  1, 7'h20, 1'b1, 4'b1101);
        add(16'hDB62, 4'h0, 4'h0, 1'b0, 2'd3, 2, 7,  1, 7'h60, 1'b1, 4'b1011);
        add(16'hDB62, 4'h0, 4'h0, 1'b0, 2'd3, 3, 7,  1, 7'h42, 1'b1, 4'b0111);

        clr        = 1'b0;
        load       = 1'b0;
        digits_in  = '0;
        dp_in      = '0;
        blank_in   = '0;
        lz_en      = 1'b0;
        brightness = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        cyc = 0;

        // Reset release: digit 0 (shadow cleared, shows 0) lit one edge later.
        step();
        check("release_seg",  32'(seg),       32'h01);
        check("release_an",   32'(anode_sig), 32'b1110);
        check("release_idx",  32'(scan_idx),  32'd0);

        // Mid-scan reset darkens everything immediately, without a clock.
        load_vals(16'h1A3F, 4'hF, 4'h0, 1'b0);
        advance_to(2, 4);
        check("prereset_an",  32'(anode_sig), 32'b1011);
        #3;
        clr = 1'b0;
        #1;
        check("reset_an",     32'(anode_sig), 32'hF);
        check("reset_seg",    32'(seg),       32'h7F);
        check("reset_dp",     32'(dp),        32'h1);
        check("reset_idx",    32'(scan_idx),  32'd0);
        check("reset_an_h",   32'(anode_h),   32'h0);
        check("reset_seg_h",  32'(seg_h),     32'h00);
        repeat (2) step();
        check("reset_hold_an", 32'(anode_sig), 32'hF);
        clr = 1'b1;
        cyc = 0;
        step();
        check("rerelease_seg", 32'(seg),       32'h01);
        check("rerelease_dp",  32'(dp),        32'h1);
        check("rerelease_an",  32'(anode_sig), 32'b1110);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            brightness = vecs[i].bright;
            load_vals(vecs[i].digits, vecs[i].dpv, vecs[i].blank, vecs[i].lz);
            advance_to(vecs[i].idx, vecs[i].pre);
            if (vecs[i].seg_chk)
                check($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
            check($sformatf("vec%0d_dp", i),  32'(dp),        32'(vecs[i].dp));
            check($sformatf("vec%0d_an", i),  32'(anode_sig), 32'(vecs[i].an));
            check($sformatf("vec%0d_idx", i), 32'(scan_idx),  32'(vecs[i].idx));
        end

        // Duty cycle over one full slot.
        brightness = 2'd0;
        advance_to(0, 15);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (anode_sig != 4'hF) lit++;
        end
        check("duty_b0", 32'(lit), 32'd4);
        brightness = 2'd2;
        advance_to(1, 15);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (anode_sig != 4'hF) lit++;
        end
        check("duty_b2", 32'(lit), 32'd12);

        // Inputs without load are ignored.
        brightness = 2'd3;
        load_vals(16'h1A3F, 4'h0, 4'h0, 1'b0);
        digits_in = 16'h2222;
        advance_to(0, 6);
        check("noload_d0", 32'(seg), 32'h38);
        advance_to(1, 6);
        check("noload_d1", 32'(seg), 32'h06);

        // Load on the slot-wrap edge: the edge itself still shows the old
        // digit with old data; the next edge shows the new digit, new data.
        advance_to(0, 14);
        load = 1'b1;
        step();
        load = 1'b0;
        check("wrapload_old_seg", 32'(seg),       32'h38);
        check("wrapload_old_an",  32'(anode_sig), 32'b1110);
        step();
        check("wrapload_new_seg", 32'(seg),       32'h12);
        check("wrapload_new_an",  32'(anode_sig), 32'b1101);
        check("wrapload_new_idx", 32'(scan_idx),  32'd1);

        // Active-high polarity: 8 with dp on digit 0.
        load_vals(16'h0008, 4'b0001, 4'h0, 1'b0);
        advance_to(0, 1);
        check("pol_seg_h", 32'(seg_h),   32'h7F);
        check("pol_dp_h",  32'(dp_h),    32'h1);
        check("pol_an_h",  32'(anode_h), 32'b0001);
        check("pol_seg_l", 32'(seg),     32'h00);
        check("pol_dp_l",  32'(dp),      32'h0);
        brightness = 2'd0;
        advance_to(0, 8);
        check("pol_off_an_h", 32'(anode_h), 32'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
